// File: rtl/esop_seq_eval_if.sv
// Config, input-vector and result handshake bundle for esop_seq_eval.
// master = producer/consumer side, slave = the evaluator.
interface esop_seq_eval_if #(
    parameter int NUM_IN = 8,
    parameter int IDX_W  = 5
);
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_addr;
    logic [NUM_IN-1:0] cfg_care;
    logic [NUM_IN-1:0] cfg_pol;
    logic              cfg_len_we;
    logic [IDX_W-1:0]  cfg_len;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    logic [NUM_IN-1:0] in_x;
    logic              out_valid;
    logic              out_ready;
    logic              out_f;
    logic              busy;

    modport master (
        output cfg_we, cfg_addr, cfg_care, cfg_pol, cfg_len_we, cfg_len,
        output in_valid, in_x, out_ready,
        input  cfg_err, in_ready, out_valid, out_f, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_care, cfg_pol, cfg_len_we, cfg_len,
        input  in_valid, in_x, out_ready,
        output cfg_err, in_ready, out_valid, out_f, busy
    );
endinterface

// File: rtl/esop_seq_eval.sv
// Programmable sequential ESOP evaluator: XOR of all enabled cubes, one shared
// match unit per cycle. Define ESOP_DUAL_EVAL_EN to evaluate two cubes per cycle.
module esop_seq_eval #(
    parameter int NUM_IN    = 8,
    parameter int MAX_CUBES = 16,
    parameter int IDX_W     = $clog2(MAX_CUBES + 1)
) (
    input logic              clk,
    input logic              rst,
    esop_seq_eval_if.slave   bus
);

    localparam int AW = (MAX_CUBES > 1) ? $clog2(MAX_CUBES) : 1;

    typedef struct packed {
        logic [NUM_IN-1:0] care;
        logic [NUM_IN-1:0] pol;
    } cube_t;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    state_t            state_q, state_d;
    cube_t             tbl_q [MAX_CUBES];
    logic [IDX_W-1:0]  num_cubes_q, num_cubes_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_IN-1:0] x_q, x_d;
    logic              acc_q, acc_d;
    logic              cfg_err_q, cfg_err_d;

    logic              cfg_open;
    logic              tbl_we;
    logic [AW-1:0]     tbl_waddr;
    logic [IDX_W-1:0]  len_clamped;
    logic [IDX_W-1:0]  len_eff;
    logic [AW-1:0]     rd0;
    logic              m0;
    logic              step_last;
    logic              step_bit;

    function automatic logic cube_match(cube_t c, logic [NUM_IN-1:0] x);
        // Don't-care literals contribute 1; cared literals must equal the polarity.
        return &(~c.care | ~(x ^ c.pol));
    endfunction

    assign cfg_open    = (state_q == S_IDLE);
    assign len_clamped = (bus.cfg_len > IDX_W'(MAX_CUBES)) ? IDX_W'(MAX_CUBES) : bus.cfg_len;
    assign len_eff     = bus.cfg_len_we ? len_clamped : num_cubes_q;
    assign tbl_we      = cfg_open && bus.cfg_we && (bus.cfg_addr < IDX_W'(MAX_CUBES));
    assign tbl_waddr   = bus.cfg_addr[AW-1:0];

    assign rd0 = idx_q[AW-1:0];
    assign m0  = cube_match(tbl_q[rd0], x_q);

`ifdef ESOP_DUAL_EVAL_EN
    logic [AW-1:0]    rd1;
    logic [IDX_W:0]   idx_p1;
    logic [IDX_W:0]   idx_p2;
    logic             m1_en;
    logic             m1;

    assign idx_p1    = {1'b0, idx_q} + (IDX_W+1)'(1);
    assign idx_p2    = {1'b0, idx_q} + (IDX_W+1)'(2);
    assign rd1       = AW'(idx_p1);
    // The second cube is masked when it lies beyond the active count.
    assign m1_en     = idx_p1 < {1'b0, num_cubes_q};
    assign m1        = m1_en & cube_match(tbl_q[rd1], x_q);
    assign step_bit  = m0 ^ m1;
    assign step_last = idx_p2 >= {1'b0, num_cubes_q};
`else
    assign step_bit  = m0;
    assign step_last = (idx_q == num_cubes_q - IDX_W'(1));
`endif

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        num_cubes_d = num_cubes_q;
        idx_d       = idx_q;
        x_d         = x_q;
        acc_d       = acc_q;
        cfg_err_d   = !cfg_open && (bus.cfg_we || bus.cfg_len_we);

        unique case (state_q)
            S_IDLE: begin
                if (bus.cfg_len_we) num_cubes_d = len_clamped;
                if (bus.in_valid) begin
                    x_d     = bus.in_x;
                    acc_d   = 1'b0;
                    idx_d   = '0;
                    state_d = (len_eff == '0) ? S_DONE : S_EVAL;
                end
            end
            S_EVAL: begin
                acc_d = acc_q ^ step_bit;
`ifdef ESOP_DUAL_EVAL_EN
                idx_d = IDX_W'(idx_p2);
`else
                idx_d = idx_q + IDX_W'(1);
`endif
                if (step_last) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            num_cubes_q <= '0;
            idx_q       <= '0;
            x_q         <= '0;
            acc_q       <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_cubes_q <= num_cubes_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // NOTE: the cube table is reset on purpose; a reset must leave an empty (all care=0) table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_CUBES; i++) tbl_q[i] <= '0;
        end else if (tbl_we) begin
            tbl_q[tbl_waddr] <= {bus.cfg_care, bus.cfg_pol};
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_f     = (state_q == S_DONE) & acc_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_esop_seq_eval.sv
// Directed bench for esop_seq_eval: vector table plus hand-written sequences for
// backpressure, dropped config writes, length clamping and reset mid-evaluation.
module tb_esop_seq_eval;

    localparam int NUM_IN    = 8;
    localparam int MAX_CUBES = 16;
    localparam int IDX_W     = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    esop_seq_eval_if #(.NUM_IN(NUM_IN), .IDX_W(IDX_W)) bus ();

    esop_seq_eval #(.NUM_IN(NUM_IN), .MAX_CUBES(MAX_CUBES), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NUM_IN-1:0] x;
        logic              f;
    } vec_t;

    function automatic int exp_lat(input int n);
`ifdef ESOP_DUAL_EVAL_EN
        return (n + 1) / 2 + 1;
`else
        return n + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_cube(input int addr, input logic [7:0] care, input logic [7:0] pol);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = IDX_W'(addr);
        bus.cfg_care = care;
        bus.cfg_pol  = pol;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic cfg_length(input int len);
        bus.cfg_len_we = 1'b1;
        bus.cfg_len    = IDX_W'(len);
        @(negedge clk);
        bus.cfg_len_we = 1'b0;
    endtask

    task automatic start_vec(input logic [7:0] x);
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        @(negedge clk);
        bus.in_valid = 1'b0;
        acc_cyc      = cyc;
    endtask

    task automatic wait_result(input string name, input logic f, input int lat);
        int t = 0;
        while (!bus.out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, " latency"}, 32'(cyc - acc_cyc + 1), 32'(lat));
        check({name, " out_f"}, 32'(bus.out_f), 32'(f));
    endtask

    task automatic consume(input string name);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
        check({name, " out_f idle"}, 32'(bus.out_f), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        int   seen;

        // c0 = 1, c1 = x7&x6, c2 = ~x5
        vecs[0] = '{x: 8'hC0, f: 1'b1};
        vecs[1] = '{x: 8'hE0, f: 1'b0};
        vecs[2] = '{x: 8'h20, f: 1'b1};
        vecs[3] = '{x: 8'h00, f: 1'b0};
        vecs[4] = '{x: 8'hFF, f: 1'b0};
        vecs[5] = '{x: 8'h40, f: 1'b0};

        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_care = '0; bus.cfg_pol = '0;
        bus.cfg_len_we = 1'b0; bus.cfg_len = '0;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_f", 32'(bus.out_f), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst cfg_err", 32'(bus.cfg_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        start_vec(8'hFF);
        wait_result("empty", 1'b0, exp_lat(0));
        consume("empty");

        cfg_cube(0, 8'h00, 8'h00);
        cfg_cube(1, 8'hC0, 8'hC0);
        cfg_cube(2, 8'h20, 8'h00);
        cfg_length(3);
        check("idle cfg_err", 32'(bus.cfg_err), 32'd0);
        cfg_cube(16, 8'hFF, 8'hFF);

        for (int i = 0; i < 6; i++) begin
            start_vec(vecs[i].x);
            wait_result($sformatf("vec%0d", i), vecs[i].f, exp_lat(3));
            consume($sformatf("vec%0d", i));
        end

        start_vec(8'hC0);
        wait_result("hold", 1'b1, exp_lat(3));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold out_valid", 32'(bus.out_valid), 32'd1);
            check("hold out_f", 32'(bus.out_f), 32'd1);
            check("hold in_ready", 32'(bus.in_ready), 32'd0);
        end
        consume("hold");

        start_vec(8'hC0);
        cfg_cube(1, 8'h00, 8'h00);
        check("busy cfg_err pulse", 32'(bus.cfg_err), 32'd1);
        @(negedge clk);
        check("busy cfg_err clear", 32'(bus.cfg_err), 32'd0);
        wait_result("busy write", 1'b1, exp_lat(3));
        consume("busy write");

        // 16 active cubes, all of which match 0xC0: even count of ones
        cfg_length(20);
        start_vec(8'hC0);
        wait_result("clamp", 1'b0, exp_lat(16));
        consume("clamp");

        bus.cfg_we = 1'b1; bus.cfg_addr = 5'd0; bus.cfg_care = 8'h01; bus.cfg_pol = 8'h01;
        bus.cfg_len_we = 1'b1; bus.cfg_len = 5'd1;
        start_vec(8'h00);
        bus.cfg_we = 1'b0; bus.cfg_len_we = 1'b0;
        wait_result("same-cycle cfg", 1'b0, exp_lat(1));
        consume("same-cycle cfg");
        start_vec(8'h01);
        wait_result("new c0", 1'b1, exp_lat(1));
        consume("new c0");

        cfg_length(16);
        start_vec(8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("midrst no out_valid", 32'(seen), 32'd0);
        start_vec(8'hFF);
        wait_result("post-rst", 1'b0, exp_lat(0));
        consume("post-rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
